// File: rtl/sap_1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, ring width and T-state patterns.
package sap_1_pkg;

   localparam int unsigned T_WIDTH = 6;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [T_WIDTH-1:0] T1_STATE = 6'b000001;
   localparam logic [T_WIDTH-1:0] T2_STATE = 6'b000010;
   localparam logic [T_WIDTH-1:0] T3_STATE = 6'b000100;
   localparam logic [T_WIDTH-1:0] T4_STATE = 6'b001000;
   localparam logic [T_WIDTH-1:0] T5_STATE = 6'b010000;
   localparam logic [T_WIDTH-1:0] T6_STATE = 6'b100000;

   function automatic logic is_one_hot(input logic [T_WIDTH-1:0] t);
      return (t != '0) && ((t & (t - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/sap_1_ring_counter.sv
// One-hot T-state ring counter with enable, early wrap to T1 and freeze.
module sap_1_ring_counter
   import sap_1_pkg::*;
(
   input  logic               CLK,
   input  logic               CLR,
   input  logic               en,
   input  logic               wrap,
   input  logic               freeze,
   output logic [T_WIDTH-1:0] T
);

   // Any corrupted (zero or multi-hot) pattern falls back to T1 on the next enabled edge.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         T <= T1_STATE;
      end else if (en && !freeze) begin
         if (!is_one_hot(T) || wrap || T[T_WIDTH-1]) begin
            T <= T1_STATE;
         end else begin
            T <= {T[T_WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter plus opcode decode and control matrix.
// Optional SAP_1_EARLY_RETIRE_EN shortens LDA (T5) and OUT/NOP (T4) machine cycles.
module sap_1_controller_sequencer
   import sap_1_pkg::*;
(
   input  logic       CLK,
   input  logic       CLR,
   input  logic       RUN,
   input  logic [3:0] OPCODE,
   output logic [6:1] T,
   output logic       Cp,
   output logic       Ep,
   output logic       EA,
   output logic       SU,
   output logic       EU,
   output logic       LMbar,
   output logic       CEbar,
   output logic       LIbar,
   output logic       EIbar,
   output logic       LAbar,
   output logic       LBbar,
   output logic       LObar,
   output logic       HLT
);

   logic [T_WIDTH-1:0] t_ring;
   logic               op_lda, op_add, op_sub, op_out, op_hlt, op_alu;
   logic               halt_now, wrap, freeze;

   assign op_lda = (OPCODE == OP_LDA);
   assign op_add = (OPCODE == OP_ADD);
   assign op_sub = (OPCODE == OP_SUB);
   assign op_out = (OPCODE == OP_OUT);
   assign op_hlt = (OPCODE == OP_HLT);
   assign op_alu = op_add | op_sub;

   assign halt_now = (t_ring == T4_STATE) && op_hlt;
   assign freeze   = HLT | halt_now;

`ifdef SAP_1_EARLY_RETIRE_EN
   assign wrap = ((t_ring == T5_STATE) && op_lda) ||
                 ((t_ring == T4_STATE) && !op_lda && !op_alu && !op_hlt);
`else
   assign wrap = 1'b0;
`endif

   sap_1_ring_counter u_ring (
      .CLK    (CLK),
      .CLR    (CLR),
      .en     (RUN),
      .wrap   (wrap),
      .freeze (freeze),
      .T      (t_ring)
   );

   assign T = t_ring;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         HLT <= 1'b0;
      end else if (RUN && halt_now) begin
         HLT <= 1'b1;
      end
   end

   always_comb begin
      Cp    = 1'b0;
      Ep    = 1'b0;
      EA    = 1'b0;
      SU    = 1'b0;
      EU    = 1'b0;
      LMbar = 1'b1;
      CEbar = 1'b1;
      LIbar = 1'b1;
      EIbar = 1'b1;
      LAbar = 1'b1;
      LBbar = 1'b1;
      LObar = 1'b1;
      if (!HLT) begin
         case (t_ring)
            T1_STATE: begin
               Ep    = 1'b1;
               LMbar = 1'b0;
            end
            T2_STATE: Cp = 1'b1;
            T3_STATE: begin
               CEbar = 1'b0;
               LIbar = 1'b0;
            end
            T4_STATE: begin
               if (op_lda || op_alu) begin
                  EIbar = 1'b0;
                  LMbar = 1'b0;
               end
               if (op_out) begin
                  EA    = 1'b1;
                  LObar = 1'b0;
               end
            end
            T5_STATE: begin
               if (op_lda) begin
                  CEbar = 1'b0;
                  LAbar = 1'b0;
               end
               if (op_alu) begin
                  CEbar = 1'b0;
                  LBbar = 1'b0;
               end
            end
            T6_STATE: begin
               if (op_alu) begin
                  LAbar = 1'b0;
                  EU    = 1'b1;
               end
               SU = op_sub;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Self-checking bench: directed scenarios then random RUN/CLR/opcode traffic against a step-number model.
module tb_sap_1_controller_sequencer;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic       RUN = 1'b0;
   logic [3:0] OPCODE = 4'b0000;
   logic [6:1] T;
   logic       Cp, Ep, EA, SU, EU, LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar, HLT;

   int n_assert = 0;
   int n_fail   = 0;
   int m_step   = 1;
   bit m_halt   = 1'b0;

   sap_1_controller_sequencer dut (
      .CLK(CLK), .CLR(CLR), .RUN(RUN), .OPCODE(OPCODE), .T(T),
      .Cp(Cp), .Ep(Ep), .EA(EA), .SU(SU), .EU(EU),
      .LMbar(LMbar), .CEbar(CEbar), .LIbar(LIbar), .EIbar(EIbar),
      .LAbar(LAbar), .LBbar(LBbar), .LObar(LObar), .HLT(HLT)
   );

   always #5 CLK = ~CLK;

   // Final step of a machine cycle for the given opcode.
   function automatic int last_step(logic [3:0] op);
`ifdef SAP_1_EARLY_RETIRE_EN
      if (op == 4'b0000) return 5;
      if (op == 4'b0001 || op == 4'b0010 || op == 4'b1111) return 6;
      return 4;
`else
      return 6;
`endif
   endfunction

   // Expected {Cp,Ep,EA,SU,EU,LMbar,CEbar,LIbar,EIbar,LAbar,LBbar,LObar}.
   function automatic logic [11:0] exp_ctrl(int s, logic [3:0] op, bit h);
      bit cp = 0, ep = 0, ea = 0, su = 0, eu = 0;
      bit lm = 0, ce = 0, li = 0, ei = 0, la = 0, lb = 0, lo = 0;
      bit ld  = (op == 4'b0000);
      bit sb  = (op == 4'b0010);
      bit alu = (op == 4'b0001) || sb;
      bit ot  = (op == 4'b1110);
      if (!h) begin
         case (s)
            1: begin ep = 1; lm = 1; end
            2: cp = 1;
            3: begin ce = 1; li = 1; end
            4: begin
               if (ld || alu) begin ei = 1; lm = 1; end
               if (ot) begin ea = 1; lo = 1; end
            end
            5: begin
               if (ld) begin ce = 1; la = 1; end
               if (alu) begin ce = 1; lb = 1; end
            end
            6: begin
               if (alu) begin la = 1; eu = 1; end
               if (sb) su = 1;
            end
            default: ;
         endcase
      end
      return {cp, ep, ea, su, eu, ~lm, ~ce, ~li, ~ei, ~la, ~lb, ~lo};
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clock(input string tag, input logic clr, input logic run, input logic [3:0] op);
      logic [5:0] exp_t;
      CLR    = clr;
      RUN    = run;
      OPCODE = op;
      @(posedge CLK);
      if (clr) begin
         m_step = 1;
         m_halt = 1'b0;
      end else if (run && !m_halt) begin
         if (m_step == 4 && op == 4'b1111) m_halt = 1'b1;
         else if (m_step >= last_step(op)) m_step = 1;
         else m_step++;
      end
      #1;
      exp_t = 6'(1 << (m_step - 1));
      check({tag, "_T"},   {6'b0, T},   {6'b0, exp_t});
      check({tag, "_HLT"}, {11'b0, HLT}, {11'b0, m_halt});
      check({tag, "_CTL"},
            {Cp, Ep, EA, SU, EU, LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar},
            exp_ctrl(m_step, op, m_halt));
   endtask

   initial begin
      logic [3:0] op;
      logic [3:0] op_pool [6];
      op_pool[0] = 4'b0000; op_pool[1] = 4'b0001; op_pool[2] = 4'b0010;
      op_pool[3] = 4'b1110; op_pool[4] = 4'b1111; op_pool[5] = 4'b0110;

      // Reset with RUN high lands in T1.
      clock("reset", 1'b1, 1'b1, 4'b0010);

      // SUB: full 6-step cycle then back to T1.
      repeat (6) clock("sub", 1'b0, 1'b1, 4'b0010);

      // HLT: reach T4, halt, stay frozen regardless of RUN, then clear.
      repeat (3) clock("hlt_fetch", 1'b0, 1'b1, 4'b1111);
      clock("hlt_edge", 1'b0, 1'b1, 4'b1111);
      repeat (10) clock("hlt_hold", 1'b0, 1'($urandom_range(0, 1)), 4'b1111);
      clock("hlt_clr", 1'b1, 1'b0, 4'b1111);

      // RUN low holds at T3 with its control lines still asserted.
      repeat (2) clock("nop_run", 1'b0, 1'b1, 4'b0101);
      repeat (5) clock("run_low", 1'b0, 1'b0, 4'b0101);
      repeat (4) clock("nop_cont", 1'b0, 1'b1, 4'b0101);

      // CLR in T5 of ADD aborts back to T1.
      clock("add_rst", 1'b1, 1'b1, 4'b0001);
      repeat (4) clock("add", 1'b0, 1'b1, 4'b0001);
      clock("add_clr", 1'b1, 1'b1, 4'b0001);

      // Cycle length for LDA and OUT.
      clock("len_rst", 1'b1, 1'b1, 4'b0000);
      repeat (7) clock("lda", 1'b0, 1'b1, 4'b0000);
      repeat (7) clock("out", 1'b0, 1'b1, 4'b1110);

      // Random traffic; opcode only changes at T1.
      op = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if (m_step == 1) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom);
            else op = op_pool[$urandom_range(0, 5)];
         end
         clock("rand", 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) != 0), op);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
